// File: rtl/hdmi_word_align.sv
// hdmi_word_align: recovers 10-bit TMDS word boundaries on the r/g/b channels by searching for control-token runs.
// Optional build macro HDMI_WORD_ALIGN_LOSSES_EN adds the per-channel saturating lock-loss counters on o_losses.

module hdmi_word_align #(
    parameter int LGTIMEOUT = 12,
    parameter int MINRUN    = 8
) (
    input  logic        i_hclk,
    input  logic        i_reset_n,
    input  logic [9:0]  i_hdmi_r,
    input  logic [9:0]  i_hdmi_g,
    input  logic [9:0]  i_hdmi_b,
    output logic [9:0]  o_hdmi_r,
    output logic [9:0]  o_hdmi_g,
    output logic [9:0]  o_hdmi_b,
    output logic [2:0]  o_locked,
    output logic [11:0] o_offset,
    output logic [23:0] o_losses
);
    localparam int RW = $clog2(MINRUN + 1);
    localparam logic [RW-1:0]        RUN_MAX   = RW'(MINRUN);
    localparam logic [RW-1:0]        RUN_LAST  = RW'(MINRUN - 1);
    localparam logic [RW-1:0]        RUN_ONE   = RW'(1);
    localparam logic [LGTIMEOUT-1:0] TIMER_ONE = LGTIMEOUT'(1);
    localparam logic [0:0]           ST_SEARCH = 1'b0;
    localparam logic [0:0]           ST_LOCKED = 1'b1;

    function automatic logic is_token(input logic [9:0] w);
        case (w)
            10'h354, 10'h0AB, 10'h154, 10'h2AB: is_token = 1'b1;
            default:                            is_token = 1'b0;
        endcase
    endfunction

    // Older word sits in the low half so a larger offset reaches further into the newer word.
    function automatic logic [9:0] align_word(input logic [9:0] cur, input logic [9:0] prev,
                                              input logic [3:0] off);
        logic [19:0] win;
        win        = {cur, prev} >> off;
        align_word = win[9:0];
    endfunction

    logic [2:0][9:0] in_all;
    logic [2:0][9:0] word_all;
    logic [2:0]      lock_all;
    logic [2:0][3:0] off_all;
    logic [2:0][7:0] loss_all;

    assign in_all = {i_hdmi_r, i_hdmi_g, i_hdmi_b};

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [9:0]           cur_q, cur_d, prev_q, prev_d, word_q, word_d;
        logic [3:0]           offset_q, offset_d;
        logic [LGTIMEOUT-1:0] timer_q, timer_d;
        logic [RW-1:0]        run_q, run_d;
        logic [1:0]           blank_q, blank_d;
        logic [0:0]           state_q, state_d;
        logic                 tok_s, listen_s, qual_s, slip_s;

        // Run/timeout decisions; a run landing on the timeout cycle suppresses the slip.
        always_comb begin
            tok_s    = is_token(word_q);
            listen_s = (blank_q == 2'd0);
            qual_s   = listen_s && tok_s && (run_q == RUN_LAST);
            slip_s   = (&timer_q) && !qual_s;
            cur_d    = in_all[c];
            prev_d   = cur_q;
            word_d   = align_word(cur_q, prev_q, offset_q);

            if (slip_s) begin
                offset_d = (offset_q == 4'd9) ? 4'd0 : (offset_q + 4'd1);
            end else begin
                offset_d = offset_q;
            end

            if (qual_s || slip_s) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TIMER_ONE;
            end

            if (slip_s || !listen_s || !tok_s) begin
                run_d = '0;
            end else if (run_q == RUN_MAX) begin
                run_d = run_q;
            end else begin
                run_d = run_q + RUN_ONE;
            end

            if (slip_s) begin
                blank_d = 2'd2;
            end else if (!listen_s) begin
                blank_d = blank_q - 2'd1;
            end else begin
                blank_d = 2'd0;
            end

            case (state_q)
                ST_SEARCH: state_d = qual_s ? ST_LOCKED : ST_SEARCH;
                ST_LOCKED: state_d = slip_s ? ST_SEARCH : ST_LOCKED;
                default:   state_d = ST_SEARCH;
            endcase
        end

        // Channel state registers with synchronous active-low reset.
        always_ff @(posedge i_hclk) begin
            if (!i_reset_n) begin
                cur_q    <= 10'h000;
                prev_q   <= 10'h000;
                word_q   <= 10'h000;
                offset_q <= 4'd0;
                timer_q  <= '0;
                run_q    <= '0;
                blank_q  <= 2'd0;
                state_q  <= ST_SEARCH;
            end else begin
                cur_q    <= cur_d;
                prev_q   <= prev_d;
                word_q   <= word_d;
                offset_q <= offset_d;
                timer_q  <= timer_d;
                run_q    <= run_d;
                blank_q  <= blank_d;
                state_q  <= state_d;
            end
        end

`ifdef HDMI_WORD_ALIGN_LOSSES_EN
        logic [7:0] losses_q, losses_d;

        // Count LOCKED->SEARCH transitions, saturating at 255.
        always_comb begin
            if (slip_s && (state_q == ST_LOCKED) && (losses_q != 8'hFF)) begin
                losses_d = losses_q + 8'd1;
            end else begin
                losses_d = losses_q;
            end
        end

        // Loss counter register.
        always_ff @(posedge i_hclk) begin
            if (!i_reset_n) begin
                losses_q <= 8'h00;
            end else begin
                losses_q <= losses_d;
            end
        end

        assign loss_all[c] = losses_q;
`else
        assign loss_all[c] = 8'h00;
`endif

        assign word_all[c] = word_q;
        assign lock_all[c] = state_q;
        assign off_all[c]  = offset_q;
    end

    assign o_hdmi_r = word_all[2];
    assign o_hdmi_g = word_all[1];
    assign o_hdmi_b = word_all[0];
    assign o_locked = lock_all;
    assign o_offset = off_all;
    assign o_losses = loss_all;

endmodule

// File: tb/tb_hdmi_word_align.sv
// tb_hdmi_word_align: randomized and directed stimulus checked every cycle against a behavioural alignment model.
// Honours HDMI_WORD_ALIGN_LOSSES_EN for the expected o_losses values.

module tb_hdmi_word_align;
    localparam int LGT  = 4;
    localparam int MR   = 8;
    localparam int TMAX = (1 << LGT) - 1;
`ifdef HDMI_WORD_ALIGN_LOSSES_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  in_r, in_g, in_b;
    logic [9:0]  o_hdmi_r, o_hdmi_g, o_hdmi_b;
    logic [2:0]  o_locked;
    logic [11:0] o_offset;
    logic [23:0] o_losses;

    always #5 clk = ~clk;

    hdmi_word_align #(.LGTIMEOUT(LGT), .MINRUN(MR)) dut (
        .i_hclk   (clk),
        .i_reset_n(rst_n),
        .i_hdmi_r (in_r),
        .i_hdmi_g (in_g),
        .i_hdmi_b (in_b),
        .o_hdmi_r (o_hdmi_r),
        .o_hdmi_g (o_hdmi_g),
        .o_hdmi_b (o_hdmi_b),
        .o_locked (o_locked),
        .o_offset (o_offset),
        .o_losses (o_losses)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int cyc    = 0;   // clock edges since reset release; edge index is cyc-1

    // Model state per channel, index 2 = r, 1 = g, 0 = b.
    int m_cur[3], m_prev[3], m_out[3], m_off[3], m_lock[3];
    int m_timer[3], m_run[3], m_blank[3], m_loss[3];
    int toks[4] = '{'h354, 'h0AB, 'h154, 'h2AB};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc - 1);
        end
    endtask

    function automatic bit is_tok(input int w);
        return (w == 'h354) || (w == 'h0AB) || (w == 'h154) || (w == 'h2AB);
    endfunction

    // Word that, read at offset k, yields w.
    function automatic int rotl(input int w, input int k);
        return ((w << k) | (w >> (10 - k))) & 1023;
    endfunction

    function automatic int inp(input int c);
        return (c == 2) ? int'(in_r) : ((c == 1) ? int'(in_g) : int'(in_b));
    endfunction

    task automatic model_step();
        int aligned, nrun;
        bit tok, listen, qual, slip;
        if (rst_n) cyc++; else cyc = 0;
        for (int c = 0; c < 3; c++) begin
            if (!rst_n) begin
                m_cur[c] = 0; m_prev[c] = 0; m_out[c] = 0; m_off[c] = 0; m_lock[c] = 0;
                m_timer[c] = 0; m_run[c] = 0; m_blank[c] = 0; m_loss[c] = 0;
            end else begin
                aligned = (((m_cur[c] << 10) | m_prev[c]) >> m_off[c]) & 1023;
                tok     = is_tok(m_out[c]);
                listen  = (m_blank[c] == 0);
                qual    = listen && tok && (m_run[c] + 1 == MR);
                slip    = (m_timer[c] == TMAX) && !qual;
                nrun    = (listen && tok && !slip) ? ((m_run[c] < MR) ? m_run[c] + 1 : MR) : 0;
                if (slip) begin
                    if (m_lock[c] != 0 && LOSS_EN && m_loss[c] < 255) m_loss[c]++;
                    m_lock[c]  = 0;
                    m_off[c]   = (m_off[c] + 1) % 10;
                    m_timer[c] = 0;
                    m_blank[c] = 2;
                end else begin
                    if (qual) begin
                        m_lock[c]  = 1;
                        m_timer[c] = 0;
                    end else begin
                        m_timer[c]++;
                    end
                    if (m_blank[c] > 0) m_blank[c]--;
                end
                m_run[c]  = nrun;
                m_out[c]  = aligned;
                m_prev[c] = m_cur[c];
                m_cur[c]  = inp(c);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input int r, input int g, input int b);
        in_r = 10'(r);
        in_g = 10'(g);
        in_b = 10'(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("o_hdmi_r", o_hdmi_r, m_out[2]);
            check("o_hdmi_g", o_hdmi_g, m_out[1]);
            check("o_hdmi_b", o_hdmi_b, m_out[0]);
            check("o_locked", o_locked, m_lock[2] * 4 + m_lock[1] * 2 + m_lock[0]);
            check("o_offset", o_offset, m_off[2] * 256 + m_off[1] * 16 + m_off[0]);
            check("o_losses", o_losses, (m_loss[2] << 16) | (m_loss[1] << 8) | m_loss[0]);
        end
    end

    initial begin
        bit saw_lock;
        int w[3], rot[3], tk[3], dens[3];
        rst_n = 1'b0;
        set_in(0, 0, 0);
        @(negedge clk);
        tick();
        cmp_en = 1'b1;
        tick();
        check("reset_locked", o_locked, 32'h0);
        check("reset_offset", o_offset, 32'h0);
        check("reset_hdmi_r", o_hdmi_r, 32'h0);
        check("reset_losses", o_losses, 32'h0);

        // Aligned lock, then loss of lock on a data-only stream.
        rst_n = 1'b1;
        for (int e = 0; e <= 26; e++) begin
            if (e <= 10) set_in('h354, 'h354, 'h354); else set_in('h1F0, 'h1F0, 'h1F0);
            tick();
            if (e == 1)  check("aligned_hdmi_r_e1", o_hdmi_r, 32'h0);
            if (e == 2) begin
                check("aligned_hdmi_r_e2", o_hdmi_r, 32'h354);
                check("aligned_hdmi_g_e2", o_hdmi_g, 32'h354);
                check("aligned_hdmi_b_e2", o_hdmi_b, 32'h354);
            end
            if (e == 9)  check("aligned_unlocked_e9", o_locked, 32'h0);
            if (e == 10) begin
                check("aligned_locked_e10", o_locked, 32'h7);
                check("aligned_offset_e10", o_offset, 32'h000);
            end
            if (e == 25) check("loss_still_locked_e25", o_locked, 32'h7);
            if (e == 26) begin
                check("loss_locked_e26", o_locked, 32'h0);
                check("loss_offset_e26", o_offset, 32'h111);
                check("loss_count_e26", o_losses, LOSS_EN ? 32'h010101 : 32'h0);
            end
        end

        // Green 0x0AB stream delayed by 3 bits; r/b carry data only.
        do_reset();
        for (int e = 0; e <= 47; e++) begin
            set_in('h1F0, 'h159, 'h1F0);
            tick();
            if (e == 14) check("search_g_off_e14", o_offset[7:4], 32'h0);
            if (e == 15) check("search_g_off_e15", o_offset[7:4], 32'h1);
            if (e == 31) check("search_g_off_e31", o_offset[7:4], 32'h2);
            if (e == 47) check("search_g_off_e47", o_offset[7:4], 32'h3);
        end
        for (int k = 0; k < 40 && !o_locked[1]; k++) tick();
        check("search_g_locked", o_locked[1], 32'h1);
        check("search_g_offset", o_offset[7:4], 32'h3);
        check("search_g_word", o_hdmi_g, 32'h0AB);

        // Runs of 7 tokens never qualify; offset wraps after 10 slips.
        do_reset();
        saw_lock = 1'b0;
        for (int e = 0; e <= 159; e++) begin
            if (e % 8 < 7) set_in('h354, 'h354, 'h354); else set_in('h1F0, 'h1F0, 'h1F0);
            tick();
            if (o_locked != 3'b000) saw_lock = 1'b1;
            if (e == 143) check("short_offset_e143", o_offset, 32'h999);
            if (e == 159) check("short_offset_e159", o_offset, 32'h000);
        end
        check("short_never_locked", saw_lock, 32'h0);

        // Eighth token lands exactly on the timeout cycle.
        do_reset();
        for (int e = 0; e <= 15; e++) begin
            if (e < 5) set_in('h1F0, 'h1F0, 'h1F0); else set_in('h354, 'h354, 'h354);
            tick();
            if (e == 14) check("simul_unlocked_e14", o_locked, 32'h0);
            if (e == 15) begin
                check("simul_locked_e15", o_locked, 32'h7);
                check("simul_offset_e15", o_offset, 32'h000);
            end
        end

        // Lock at offset 5, then a one-edge reset.
        do_reset();
        set_in('h29A, 'h29A, 'h29A);
        for (int k = 0; k < 150 && o_locked != 3'b111; k++) tick();
        check("midlock_locked", o_locked, 32'h7);
        check("midlock_offset", o_offset, 32'h555);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_locked", o_locked, 32'h0);
        check("midreset_offset", o_offset, 32'h0);
        check("midreset_hdmi_r", o_hdmi_r, 32'h0);
        check("midreset_hdmi_g", o_hdmi_g, 32'h0);
        check("midreset_hdmi_b", o_hdmi_b, 32'h0);
        check("midreset_losses", o_losses, 32'h0);

        // Repeated lock/loss cycles, following the current offset, to saturate the loss counters.
        for (int k = 0; k < 9500; k++) begin
            set_in(rotl('h354, m_off[2]), rotl('h354, m_off[1]), rotl('h354, m_off[0]));
            tick();
        end
        check("losses_saturated", o_losses, LOSS_EN ? 32'hFFFFFF : 32'h0);

        // Random token-rich segments with occasional reset.
        for (int s = 0; s < 100; s++) begin
            for (int c = 0; c < 3; c++) begin
                rot[c]  = $urandom_range(0, 9);
                tk[c]   = toks[$urandom_range(0, 3)];
                dens[c] = $urandom_range(10, 16);
            end
            for (int k = 0; k < 30; k++) begin
                for (int c = 0; c < 3; c++) begin
                    w[c] = ($urandom_range(0, 15) < dens[c]) ? rotl(tk[c], rot[c]) : $urandom_range(0, 1023);
                end
                set_in(w[2], w[1], w[0]);
                rst_n = ($urandom_range(0, 399) != 0);
                tick();
            end
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
